mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
// - MEM-stage data-memory controller for the 16-bit pipelined CPU; consumes the
//   effective address produced by the LW/SW address-generation stage.
// - Sequences one load/store per request against a multi-cycle data memory with
//   an ack handshake; stalls the pipeline until completion; returns load data.
// - Bounds every access with a timeout counter and flags a bus error on expiry.
// PARAMETERS
// - ADDR_W   16  address width; must be 16 in this CPU
// - DATA_W   16  data word width
// - TIMEOUT  15  max WAIT cycles before abort; legal range 1..2**CNT_W-1
// - CNT_W     4  timeout counter width
// PORTS
// - clk          in   1       single clock; all state changes on rising edge
// - rst          in   1       synchronous, active-high reset
// - req_valid    in   1       EX/MEM holds a memory instruction
// - req_is_load  in   1       LW
// - req_is_store in   1       SW; if both load and store are set, store wins
// - req_addr     in   ADDR_W  effective address from address generation
// - req_wdata    in   DATA_W  store data
// - stall        out  1       hold PC/IF/ID/EX/MEM pipeline registers
// - done         out  1       one-cycle completion pulse
// - rdata        out  DATA_W  load result; valid while done=1
// - bus_err      out  1       with done: access timed out
// - mem_en       out  1       one-cycle request strobe to data memory
// - mem_wr       out  1       1=write; valid with mem_en
// - mem_addr     out  ADDR_W  registered word-aligned address
// - mem_wdata    out  DATA_W  registered store data
// - mem_ack      in   1       memory completion; sampled only in WAIT
// - mem_rdata    in   DATA_W  read data; valid with mem_ack
// BEHAVIOUR
// - Reset: state=IDLE; stall/done/bus_err/mem_en/mem_wr=0; rdata, mem_addr,
//   mem_wdata, counter=0. Reset mid-access aborts it with no done pulse.
// - Any mem_ack arriving after that reset is ignored, since IDLE does not sample ack.
// - FSM: IDLE(00) ISSUE(01) WAIT(10) DONE(11)
// - IDLE: accept when req_valid & (req_is_load | req_is_store).
//   - stall=1 combinationally in the accept cycle.
//   - Latch mem_addr = req_addr & 16'hFFFE, mem_wdata, and mem_wr.
//   - Go to ISSUE. Otherwise stall=0 and stay in IDLE.
// - ISSUE: mem_en=1 for exactly this cycle; stall=1; counter<=0; go to WAIT.
//   - mem_ack is ignored in ISSUE.
// - WAIT: stall=1; mem_en=0.
//   - On mem_ack: capture rdata<=mem_rdata for a load (rdata unchanged for a
//     store); bus_err<=0; go to DONE.
//   - Else, if counter==TIMEOUT-1: rdata<=0; bus_err<=1; go to DONE.
//   - Else counter++.
//   - mem_ack wins over a simultaneous timeout.
// - DONE: done=1; stall=0 so the pipeline advances; always return to IDLE.
//   - A request still visible on the inputs this cycle is not re-accepted.
// - Latency: ack in the k-th WAIT cycle gives done at accept + 2 + k cycles.
//   - Minimum accept-to-done is 3 cycles.
// - stall is 1 from the accept cycle through the last WAIT cycle inclusive.
// - req_* may change while stall=1; only the values latched at accept are used.
// - rdata holds its last value outside DONE; bus_err clears on the next accept.
// STRUCTURE
// - Shared package mem_pkg:
//   - state typedef/localparams S_IDLE..S_DONE
//   - ALIGN_MASK = 16'hFFFE
//   - default TIMEOUT
// - One sub-module: mem_timeout_cnt (CNT_W counter; clear, enable, expire output).
// - FSM next-state logic and output registers stay in the top module.
// TESTING
// - Load: req_addr=16'h0013, ack with mem_rdata=16'hBEEF on the 2nd WAIT cycle
//   -> mem_addr=16'h0012, mem_wr=0, done at accept+4, rdata=16'hBEEF.
// - Store: req_addr=16'h0040, req_wdata=16'h1234, ack on the 1st WAIT cycle
//   -> mem_wr=1, mem_wdata=16'h1234, one mem_en pulse, stall 3 cycles, done once.
// - Timeout: load with no ack, TIMEOUT=15
//   -> done at accept+17, bus_err=1, rdata=0, stall released.
// - Ack coincident with the timeout cycle -> bus_err=0, rdata=mem_rdata.
// - Back-to-back: req_valid held high across DONE
//   -> no re-accept in DONE; a new request in the next IDLE is accepted.
// - Reset asserted in WAIT, then a late mem_ack
//   -> IDLE, all outputs 0, no done pulse, late ack ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory controller: FSM encoding,
// word-alignment mask and default timeout sizing.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_DONE  = 2'b11
  } memState;

  // Loads and stores are word accesses, so bit 0 of the address is dropped.
  localparam logic [15:0] ALIGN_MASK = 16'hFFFE;

  localparam int TIMEOUT_DEFAULT = 15;
  localparam int CNT_W_DEFAULT   = 4;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Pipeline-request and data-memory bus bundle for the MEM-stage controller.
// The controller uses the slave view; the pipeline/memory side uses master.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  // Pipeline request side
  logic              req_valid;
  logic              req_is_load;
  logic              req_is_store;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              stall;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              bus_err;

  // Data memory side
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_is_load, req_is_store, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output stall, done, rdata, bus_err,
    output mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_is_load, req_is_store, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  stall, done, rdata, bus_err,
    input  mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_timeout_cnt.sv
// Wait-cycle counter for a single memory access; expired is high in the
// cycle that would be the TIMEOUT-th wait cycle.
module mem_timeout_cnt #(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] count;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory controller: one load/store per request against an
// ack-handshaked memory, with pipeline stall and a bounded wait.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  mem_access_ctrl_if.slave bus
);

  memState           state;
  logic              accept;
  logic              stall;
  logic              cntClr;
  logic              cntEn;
  logic              cntExpired;

  logic              memEnR;
  logic              memWrR;
  logic              doneR;
  logic              busErrR;
  logic [ADDR_W-1:0] memAddrR;
  logic [DATA_W-1:0] memWdataR;
  logic [DATA_W-1:0] rdataR;

  // DONE is excluded by the state test, so a request still held there waits
  // for the following IDLE cycle.
  assign accept = (state == S_IDLE) && bus.req_valid &&
                  (bus.req_is_load || bus.req_is_store);

  // NOTE: the default assignment first keeps this purely combinational;
  // without it a missed branch would infer a latch.
  always_comb begin
    stall = 1'b0;
    case (state)
      S_IDLE:          stall = accept;
      S_ISSUE, S_WAIT: stall = 1'b1;
      default:         stall = 1'b0;
    endcase
  end

  assign cntClr = (state == S_ISSUE);
  assign cntEn  = (state == S_WAIT) && !bus.mem_ack && !cntExpired;

  mem_timeout_cnt #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) timeoutCnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (cntClr),
    .en      (cntEn),
    .expired (cntExpired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      memEnR    <= 1'b0;
      memWrR    <= 1'b0;
      doneR     <= 1'b0;
      busErrR   <= 1'b0;
      memAddrR  <= '0;
      memWdataR <= '0;
      rdataR    <= '0;
    end else begin
      memEnR <= 1'b0;
      doneR  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            memAddrR  <= bus.req_addr & ADDR_W'(ALIGN_MASK);
            memWdataR <= bus.req_wdata;
            memWr_latch: memWrR <= bus.req_is_store;
            busErrR   <= 1'b0;
            memEnR    <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          // An ack in the expiry cycle still completes the access normally.
          if (bus.mem_ack) begin
            if (!memWrR) begin
              rdataR <= bus.mem_rdata;
            end
            busErrR <= 1'b0;
            doneR   <= 1'b1;
            state   <= S_DONE;
          end else if (cntExpired) begin
            rdataR  <= '0;
            busErrR <= 1'b1;
            doneR   <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.stall     = stall;
  assign bus.done      = doneR;
  assign bus.rdata     = rdataR;
  assign bus.bus_err   = busErrR;
  assign bus.mem_en    = memEnR;
  assign bus.mem_wr    = memWrR;
  assign bus.mem_addr  = memAddrR;
  assign bus.mem_wdata = memWdataR;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, hand-written back-to-back
// and reset-abort sequences, then random transactions against a reference model.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 15;

  typedef struct {
    string       name;
    bit          isLoad;
    bit          isStore;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] ackData;
    int          ackAt;     // WAIT cycle carrying the ack; 0 = no ack
    int          expDone;   // cycles from accept to the done pulse
    bit          expErr;
    logic [15:0] expRdata;
    logic [15:0] expAddr;
    bit          expWr;
  } vecT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int nChecks = 0;
  int nPass   = 0;
  logic [15:0] modelRdata = '0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .TIMEOUT (TIMEOUT),
    .CNT_W   (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic vecT mkVec(input string name, input bit ld, input bit st,
                                input logic [15:0] addr, input logic [15:0] wdata,
                                input logic [15:0] ackData, input int ackAt,
                                input int expDone, input bit expErr,
                                input logic [15:0] expRdata, input logic [15:0] expAddr,
                                input bit expWr);
    vecT v;
    v.name = name; v.isLoad = ld; v.isStore = st; v.addr = addr; v.wdata = wdata;
    v.ackData = ackData; v.ackAt = ackAt; v.expDone = expDone; v.expErr = expErr;
    v.expRdata = expRdata; v.expAddr = expAddr; v.expWr = expWr;
    return v;
  endfunction

  // Reference model: an access either sees its ack within TIMEOUT wait cycles
  // or is aborted; only a completed load updates the returned data.
  function automatic void refModel(input bit isStore, input int ackAt, input logic [15:0] ackData,
                                   output int expDone, output bit expErr,
                                   output logic [15:0] expRdata);
    bit acked;
    acked   = (ackAt >= 1) && (ackAt <= TIMEOUT);
    expDone = 2 + (acked ? ackAt : TIMEOUT);
    expErr  = !acked;
    if (!acked)        modelRdata = '0;
    else if (!isStore) modelRdata = ackData;
    expRdata = modelRdata;
  endfunction

  task automatic runTxn(input string name, input bit isLoad, input bit isStore,
                        input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] ackData, input int ackAt,
                        input int expDone, input bit expErr, input logic [15:0] expRdata,
                        input logic [15:0] expAddr, input bit expWr,
                        input bit scramble, input bit chain);
    int doneAt, doneCnt, enAt, enCnt, stallCnt;
    bit ackNow;
    logic [15:0] addrAtEn, wdataAtEn, rdataAtDone;
    logic wrAtEn, errAtEn, errAtDone;
    doneAt = -1; doneCnt = 0; enAt = -1; enCnt = 0; stallCnt = 0;
    addrAtEn = '0; wdataAtEn = '0; rdataAtDone = '0;
    wrAtEn = 1'b0; errAtEn = 1'b1; errAtDone = 1'b0;

    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_is_load  = isLoad;
    bus.req_is_store = isStore;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.mem_ack      = 1'b0;
    #1;
    if (bus.stall) stallCnt++;

    for (int c = 1; c <= expDone + 1; c++) begin
      @(posedge clk);
      #1;
      ackNow        = (ackAt > 0) && (c == ackAt + 1);
      bus.mem_ack   = ackNow;
      bus.mem_rdata = ackNow ? ackData : 16'($urandom);
      if (scramble && !ackNow && (c == 1 || c >= expDone))
        bus.mem_ack = 1'($urandom_range(0, 1));
      if (c >= expDone) begin
        if (chain) begin
          bus.req_valid    = 1'b1;
          bus.req_is_load  = 1'b1;
          bus.req_is_store = 1'b0;
        end else if (scramble && c == expDone) begin
          bus.req_valid    = 1'b1;
          bus.req_is_load  = 1'($urandom_range(0, 1));
          bus.req_is_store = 1'($urandom_range(0, 1));
        end else begin
          bus.req_valid = 1'b0;
        end
      end else if (scramble) begin
        bus.req_valid    = 1'($urandom_range(0, 1));
        bus.req_is_load  = 1'($urandom_range(0, 1));
        bus.req_is_store = 1'($urandom_range(0, 1));
        bus.req_addr     = 16'($urandom);
        bus.req_wdata    = 16'($urandom);
      end else begin
        bus.req_valid = 1'b0;
      end
      #1;
      if (bus.stall && c <= expDone) stallCnt++;
      if (bus.mem_en) begin
        enCnt++; enAt = c;
        addrAtEn = bus.mem_addr; wdataAtEn = bus.mem_wdata;
        wrAtEn = bus.mem_wr; errAtEn = bus.bus_err;
      end
      if (bus.done) begin
        doneCnt++; doneAt = c;
        errAtDone = bus.bus_err; rdataAtDone = bus.rdata;
      end
    end
    if (!chain) bus.mem_ack = 1'b0;

    check({name, "/done_at"},     doneAt,      expDone);
    check({name, "/done_count"},  doneCnt,     1);
    check({name, "/mem_en_at"},   enAt,        1);
    check({name, "/mem_en_cnt"},  enCnt,       1);
    check({name, "/stall_cyc"},   stallCnt,    expDone);
    check({name, "/mem_addr"},    addrAtEn,    expAddr);
    check({name, "/mem_wr"},      wrAtEn,      expWr);
    check({name, "/mem_wdata"},   wdataAtEn,   wdata);
    check({name, "/err_cleared"}, errAtEn,     1'b0);
    check({name, "/bus_err"},     errAtDone,   expErr);
    check({name, "/rdata"},       rdataAtDone, expRdata);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecT vecs[8];
    int typ, ackAt, expDone, lateDone, lateStall, lateEn;
    bit expErr, ld, st;
    logic [15:0] addr, wdata, ackData, expRdata;

    vecs[0] = mkVec("load_ack2",       1, 0, 16'h0013, 16'h0000, 16'hBEEF,  2,  4, 0, 16'hBEEF, 16'h0012, 0);
    vecs[1] = mkVec("store_ack1",      0, 1, 16'h0040, 16'h1234, 16'h9999,  1,  3, 0, 16'hBEEF, 16'h0040, 1);
    vecs[2] = mkVec("load_timeout",    1, 0, 16'h0101, 16'h0000, 16'h0000,  0, 17, 1, 16'h0000, 16'h0100, 0);
    vecs[3] = mkVec("ack_at_expiry",   1, 0, 16'h0202, 16'h0000, 16'hA5A5, 15, 17, 0, 16'hA5A5, 16'h0202, 0);
    vecs[4] = mkVec("store_wins",      1, 1, 16'hFFFF, 16'h0F0F, 16'h1111,  3,  5, 0, 16'hA5A5, 16'hFFFE, 1);
    vecs[5] = mkVec("store_timeout",   0, 1, 16'h8001, 16'h5A5A, 16'h0000,  0, 17, 1, 16'h0000, 16'h8000, 1);
    vecs[6] = mkVec("ack_after_expiry",1, 0, 16'h0007, 16'h0000, 16'h2222, 16, 17, 1, 16'h0000, 16'h0006, 0);
    vecs[7] = mkVec("load_min_lat",    1, 0, 16'h1234, 16'h0000, 16'hCAFE,  1,  3, 0, 16'hCAFE, 16'h1234, 0);

    bus.req_valid = 1'b0; bus.req_is_load = 1'b0; bus.req_is_store = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    repeat (3) @(posedge clk);
    #2;
    check("reset/stall",     bus.stall,     0);
    check("reset/done",      bus.done,      0);
    check("reset/bus_err",   bus.bus_err,   0);
    check("reset/mem_en",    bus.mem_en,    0);
    check("reset/mem_wr",    bus.mem_wr,    0);
    check("reset/mem_addr",  bus.mem_addr,  0);
    check("reset/mem_wdata", bus.mem_wdata, 0);
    check("reset/rdata",     bus.rdata,     0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      runTxn(vecs[i].name, vecs[i].isLoad, vecs[i].isStore, vecs[i].addr, vecs[i].wdata,
             vecs[i].ackData, vecs[i].ackAt, vecs[i].expDone, vecs[i].expErr,
             vecs[i].expRdata, vecs[i].expAddr, vecs[i].expWr, (i % 2) == 1, 1'b0);
    end
    modelRdata = 16'hCAFE;

    // Request held high through DONE: only the following IDLE may accept it.
    runTxn("b2b_first",  1, 0, 16'h0300, 16'h0000, 16'h3333, 1, 3, 0, 16'h3333, 16'h0300, 0, 1'b0, 1'b1);
    runTxn("b2b_second", 1, 0, 16'h0302, 16'h0000, 16'h4444, 2, 4, 0, 16'h4444, 16'h0302, 0, 1'b0, 1'b0);

    // Reset in the third WAIT cycle of a store, then a late ack.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_is_load = 1'b0; bus.req_is_store = 1'b1;
    bus.req_addr = 16'h0F0F; bus.req_wdata = 16'hCAFE; bus.mem_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    #1;
    check("rst_mid/stall_before",  bus.stall,  1);
    check("rst_mid/mem_wr_before", bus.mem_wr, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("rst_mid/stall",     bus.stall,     0);
    check("rst_mid/done",      bus.done,      0);
    check("rst_mid/bus_err",   bus.bus_err,   0);
    check("rst_mid/mem_en",    bus.mem_en,    0);
    check("rst_mid/mem_wr",    bus.mem_wr,    0);
    check("rst_mid/mem_addr",  bus.mem_addr,  0);
    check("rst_mid/mem_wdata", bus.mem_wdata, 0);
    check("rst_mid/rdata",     bus.rdata,     0);
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = 16'h5555;
    lateDone = 0; lateStall = 0; lateEn = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) bus.mem_ack = 1'b0;
      #1;
      if (bus.done)   lateDone++;
      if (bus.stall)  lateStall++;
      if (bus.mem_en) lateEn++;
    end
    check("late_ack/done_pulses", lateDone,  0);
    check("late_ack/stall_cyc",   lateStall, 0);
    check("late_ack/mem_en",      lateEn,    0);
    check("late_ack/rdata",       bus.rdata, 0);
    modelRdata = '0;

    for (int i = 0; i < 40; i++) begin
      typ     = $urandom_range(0, 2);
      ld      = (typ != 1);
      st      = (typ != 0);
      ackAt   = $urandom_range(0, 17);
      addr    = 16'($urandom);
      wdata   = 16'($urandom);
      ackData = 16'($urandom);
      refModel(st, ackAt, ackData, expDone, expErr, expRdata);
      runTxn($sformatf("rand%0d", i), ld, st, addr, wdata, ackData, ackAt,
             expDone, expErr, expRdata, addr & 16'hFFFE, st, 1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
